// File: rtl/srm_ctrl_pkg.sv
// Shared types and encodings for the Simple RISC Machine controller.
// Optional retire counter is enabled with SRM_RETIRE_COUNT_EN.
package srm_ctrl_pkg;

  typedef enum logic [2:0] {
    S_WAIT,
    S_DECODE,
    S_GET_A,
    S_GET_B,
    S_ALU,
    S_WRITE_REG,
    S_WRITE_IMM
  } state_e;

  typedef enum logic [2:0] {
    CLS_ILLEGAL,
    CLS_MOV_IMM,
    CLS_MOV_REG,
    CLS_ADD,
    CLS_CMP,
    CLS_AND,
    CLS_MVN
  } cls_e;

  localparam logic [2:0] OPC_MOV    = 3'b110;
  localparam logic [2:0] OPC_ALU    = 3'b101;

  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_AND     = 2'b10;
  localparam logic [1:0] OP_MVN     = 2'b11;

  localparam logic [1:0] VSEL_C     = 2'b00;
  localparam logic [1:0] VSEL_PC    = 2'b01;
  localparam logic [1:0] VSEL_IMM   = 2'b10;
  localparam logic [1:0] VSEL_MDATA = 2'b11;

endpackage

// File: rtl/srm_instr_decoder.sv
// Combinational instruction decoder: splits IR into fields, sign-extends
// the 8-bit immediate and classifies the encoding.
module srm_instr_decoder
  import srm_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = 16
) (
  input  logic [15:0]       ir_i,
  output logic [2:0]        rn_o,
  output logic [2:0]        rd_o,
  output logic [2:0]        rm_o,
  output logic [1:0]        sh_o,
  output logic [1:0]        op_o,
  output logic [DATA_W-1:0] sximm8_o,
  output cls_e              cls_o,
  output logic              legal_o
);

  logic [2:0] opc;

  assign opc      = ir_i[15:13];
  assign op_o     = ir_i[12:11];
  assign rn_o     = ir_i[10:8];
  assign rd_o     = ir_i[7:5];
  assign sh_o     = ir_i[4:3];
  assign rm_o     = ir_i[2:0];
  assign sximm8_o = {{(DATA_W-8){ir_i[7]}}, ir_i[7:0]};

  always_comb begin
    cls_o = CLS_ILLEGAL;
    case ({opc, op_o})
      {OPC_MOV, OP_MOV_IMM}: cls_o = CLS_MOV_IMM;
      {OPC_MOV, OP_MOV_REG}: cls_o = CLS_MOV_REG;
      {OPC_ALU, OP_ADD}:     cls_o = CLS_ADD;
      {OPC_ALU, OP_CMP}:     cls_o = CLS_CMP;
      {OPC_ALU, OP_AND}:     cls_o = CLS_AND;
      {OPC_ALU, OP_MVN}:     cls_o = CLS_MVN;
      default:               cls_o = CLS_ILLEGAL;
    endcase
  end

  assign legal_o = (cls_o != CLS_ILLEGAL);

endmodule

// File: rtl/srm_controller.sv
// IR, decoder and multi-cycle control FSM driving the SRM datapath.
// Define SRM_RETIRE_COUNT_EN to add the `retired` instruction counter port.
module srm_controller
  import srm_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              s,
  input  logic              load,
  input  logic [15:0]       instr,
  output logic              w,
  output logic [2:0]        readnum,
  output logic [2:0]        writenum,
  output logic              write,
  output logic [1:0]        vsel,
  output logic              loada,
  output logic              loadb,
  output logic              loadc,
  output logic              loads,
  output logic              asel,
  output logic              bsel,
  output logic [1:0]        shift,
  output logic [1:0]        ALUop,
  output logic [DATA_W-1:0] sximm8,
  output logic              illegal
`ifdef SRM_RETIRE_COUNT_EN
  ,
  output logic [15:0]       retired
`endif
);

  state_e      state_q, state_d;
  logic [15:0] ir_q, ir_d;

  logic [2:0]  rn, rd, rm;
  logic [1:0]  sh, op;
  cls_e        cls;
  logic        legal;

  srm_instr_decoder #(
    .DATA_W (DATA_W)
  ) u_dec (
    .ir_i     (ir_q),
    .rn_o     (rn),
    .rd_o     (rd),
    .rm_o     (rm),
    .sh_o     (sh),
    .op_o     (op),
    .sximm8_o (sximm8),
    .cls_o    (cls),
    .legal_o  (legal)
  );

  assign shift = sh;
  // MOV Rd,Rm runs through the adder with A forced to zero.
  assign ALUop = (cls == CLS_MOV_REG) ? OP_ADD : op;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_WAIT;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ir_d     = ir_q;
    w        = 1'b0;
    readnum  = '0;
    writenum = '0;
    write    = 1'b0;
    vsel     = VSEL_C;
    loada    = 1'b0;
    loadb    = 1'b0;
    loadc    = 1'b0;
    loads    = 1'b0;
    asel     = 1'b0;
    bsel     = 1'b0;
    illegal  = 1'b0;

    case (state_q)
      S_WAIT: begin
        w = 1'b1;
        if (load) ir_d = instr;
        if (s) state_d = S_DECODE;
      end
      S_DECODE: begin
        if (!legal) begin
          illegal = 1'b1;
          state_d = S_WAIT;
        end else begin
          case (cls)
            CLS_MOV_IMM:                 state_d = S_WRITE_IMM;
            CLS_MOV_REG, CLS_MVN:        state_d = S_GET_B;
            default:                     state_d = S_GET_A;
          endcase
        end
      end
      S_GET_A: begin
        readnum = rn;
        loada   = 1'b1;
        state_d = S_GET_B;
      end
      S_GET_B: begin
        readnum = rm;
        loadb   = 1'b1;
        state_d = S_ALU;
      end
      S_ALU: begin
        asel = (cls == CLS_MOV_REG) || (cls == CLS_MVN);
        if (cls == CLS_CMP) begin
          loads   = 1'b1;
          state_d = S_WAIT;
        end else begin
          loadc   = 1'b1;
          state_d = S_WRITE_REG;
        end
      end
      S_WRITE_REG: begin
        writenum = rd;
        vsel     = VSEL_C;
        write    = 1'b1;
        state_d  = S_WAIT;
      end
      S_WRITE_IMM: begin
        writenum = rn;
        vsel     = VSEL_IMM;
        write    = 1'b1;
        state_d  = S_WAIT;
      end
      default: state_d = S_WAIT;
    endcase
  end

`ifdef SRM_RETIRE_COUNT_EN
  logic [15:0] retired_q, retired_d;
  logic        retire;

  // Each of these states is always followed by WAIT, so this marks entry to WAIT.
  assign retire = (state_q == S_WRITE_REG) || (state_q == S_WRITE_IMM) ||
                  ((state_q == S_ALU) && (cls == CLS_CMP));

  always_comb begin
    retired_d = retired_q;
    if (retire) retired_d = retired_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) retired_q <= '0;
    else          retired_q <= retired_d;
  end

  assign retired = retired_q;
`endif

endmodule

// File: tb/tb_srm_controller.sv
// Self-checking bench for srm_controller: per-cycle instruction-level model
// plus directed scenarios with literal expectations.
module tb_srm_controller;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        s = 1'b0;
  logic        load = 1'b0;
  logic [15:0] instr = '0;

  logic        w, write, loada, loadb, loadc, loads, asel, bsel, illegal;
  logic [2:0]  readnum, writenum;
  logic [1:0]  vsel, shift, ALUop;
  logic [15:0] sximm8;
`ifdef SRM_RETIRE_COUNT_EN
  logic [15:0] retired;
`endif

  srm_controller #(
    .DATA_W (16)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .s        (s),
    .load     (load),
    .instr    (instr),
    .w        (w),
    .readnum  (readnum),
    .writenum (writenum),
    .write    (write),
    .vsel     (vsel),
    .loada    (loada),
    .loadb    (loadb),
    .loadc    (loadc),
    .loads    (loads),
    .asel     (asel),
    .bsel     (bsel),
    .shift    (shift),
    .ALUop    (ALUop),
    .sximm8   (sximm8),
    .illegal  (illegal)
`ifdef SRM_RETIRE_COUNT_EN
    ,
    .retired  (retired)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected control-output vector for one cycle.
  typedef struct packed {
    logic       w;
    logic [2:0] rn;
    logic [2:0] wn;
    logic       wr;
    logic [1:0] vs;
    logic       la, lb, lc, ls, as, bs, il;
  } ctl_t;

  ctl_t        seq[$];
  logic [15:0] m_ir = '0;
  logic        m_legal = 1'b0;
  logic [15:0] m_retired = '0;
  logic        chk_en = 1'b0;

  // Expand one instruction into its list of non-idle cycles.
  task automatic plan(input logic [15:0] ir);
    logic is_movi, is_movr, is_alu, is_cmp, is_mvn, legal;
    ctl_t c;
    is_movi = (ir[15:11] == 5'b11010);
    is_movr = (ir[15:11] == 5'b11000);
    is_alu  = (ir[15:13] == 3'b101);
    is_cmp  = (ir[15:11] == 5'b10101);
    is_mvn  = (ir[15:11] == 5'b10111);
    legal   = is_movi | is_movr | is_alu;
    m_legal = legal;
    c = '0; c.il = !legal;
    seq.push_back(c);
    if (is_movi) begin
      c = '0; c.wn = ir[10:8]; c.vs = 2'b10; c.wr = 1'b1;
      seq.push_back(c);
    end else if (legal) begin
      if (is_alu && !is_mvn) begin
        c = '0; c.rn = ir[10:8]; c.la = 1'b1;
        seq.push_back(c);
      end
      c = '0; c.rn = ir[2:0]; c.lb = 1'b1;
      seq.push_back(c);
      c = '0; c.as = is_movr | is_mvn; c.ls = is_cmp; c.lc = !is_cmp;
      seq.push_back(c);
      if (!is_cmp) begin
        c = '0; c.wn = ir[7:5]; c.wr = 1'b1;
        seq.push_back(c);
      end
    end
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_ir = '0;
      seq.delete();
      m_legal = 1'b0;
      m_retired = '0;
    end else if (seq.size() != 0) begin
      seq.delete(0);
      if (seq.size() == 0 && m_legal) m_retired = m_retired + 16'd1;
    end else begin
      if (load) m_ir = instr;
      if (s) plan(m_ir);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      ctl_t e, a;
      logic [1:0] aluop_e;
      e = '0; e.w = 1'b1;
      if (seq.size() != 0) e = seq[0];
      a = {w, readnum, writenum, write, vsel, loada, loadb, loadc, loads, asel, bsel, illegal};
      chk("ctl", 32'(a), 32'(e));
      aluop_e = (m_ir[15:11] == 5'b11000) ? 2'b00 : m_ir[12:11];
      chk("dp", {12'd0, shift, ALUop, sximm8},
          {12'd0, m_ir[4:3], aluop_e, {8{m_ir[7]}}, m_ir[7:0]});
`ifdef SRM_RETIRE_COUNT_EN
      chk("retired", 32'(retired), 32'(m_retired));
`endif
    end
  end

  // Starts an instruction; returns at the negedge where DECODE is visible.
  task automatic kick(input logic [15:0] word, input logic ld);
    @(negedge clk);
    instr = word; load = ld; s = 1'b1;
    @(negedge clk);
    load = 1'b0; s = 1'b0;
  endtask

  task automatic lat(input string name, input int exp);
    int n;
    n = 0;
    while (w === 1'b0 && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk(name, n, exp);
  endtask

  logic [15:0] lat_words [9] = '{16'hD105, 16'hC020, 16'hB820, 16'hA900, 16'hA148,
                                 16'hB162, 16'h0000, 16'hC800, 16'hE0FF};
  int          lat_exp   [9] = '{2, 4, 4, 4, 5, 5, 1, 1, 1};

  initial begin
    int ones;
    logic [15:0] rbase;
    #1 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_w", w, 1);
    chk("rst_idle", {write, loads, illegal, vsel, asel, bsel, readnum, writenum}, 0);
    chk("rst_sximm8", sximm8, 0);
    reset_n = 1'b1;
    chk_en = 1'b1;

    // MOV R1,#5
    kick(16'hD105, 1'b1);
    chk("movi_dec_w", w, 0);
    @(negedge clk);
    chk("movi_wr", {writenum, vsel, write}, {3'd1, 2'b10, 1'b1});
    chk("movi_imm", sximm8, 16'h0005);
    @(negedge clk);
    chk("movi_done", w, 1);

    // MOV R2,#-1
    kick(16'hD2FF, 1'b1);
    @(negedge clk);
    chk("movneg_imm", sximm8, 16'hFFFF);
    chk("movneg_wn", writenum, 2);
    @(negedge clk);

    // ADD R2,R1,R0 LSL#1
    kick(16'hA148, 1'b1);
    @(negedge clk);
    chk("add_geta", {readnum, loada}, {3'd1, 1'b1});
    @(negedge clk);
    chk("add_getb", {readnum, loadb}, {3'd0, 1'b1});
    @(negedge clk);
    chk("add_alu", {loadc, ALUop, shift}, {1'b1, 2'b00, 2'b01});
    @(negedge clk);
    chk("add_wr", {writenum, write}, {3'd2, 1'b1});
    @(negedge clk);
    chk("add_done", w, 1);

    // CMP R1,R0
    kick(16'hA900, 1'b1);
    repeat (3) @(negedge clk);
    chk("cmp_alu", {loads, loadc}, 2'b10);
    @(negedge clk);
    chk("cmp_done", w, 1);

    for (int i = 0; i < 9; i++) begin
      kick(lat_words[i], 1'b1);
      lat($sformatf("lat_%h", lat_words[i]), lat_exp[i]);
    end

    // load during execution is ignored
`ifdef SRM_RETIRE_COUNT_EN
    rbase = retired;
`else
    rbase = '0;
`endif
    kick(16'hA148, 1'b1);
    load = 1'b1; instr = 16'hD2FF;
    lat("ldbusy_lat", 5);
    load = 1'b0;
    chk("ldbusy_ir", sximm8, 16'h0048);
`ifdef SRM_RETIRE_COUNT_EN
    chk("ldbusy_ret", retired - rbase, 1);
`endif

    // s held high: back-to-back re-execution
    @(negedge clk);
    instr = 16'hD105; load = 1'b1; s = 1'b1;
    @(negedge clk);
    load = 1'b0;
    ones = 0;
    for (int i = 0; i < 6; i++) begin
      ones += int'(w);
      if (i == 5) s = 1'b0;
      @(negedge clk);
    end
    chk("b2b_wait_cycles", ones, 2);

    // reset in the middle of ADD (GET_B)
    kick(16'hA148, 1'b1);
    repeat (2) @(negedge clk);
    chk("midrst_pre", loadb, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_w", w, 1);
    chk("midrst_lb", {loadb, readnum}, 0);
    chk("midrst_ir", sximm8, 0);
`ifdef SRM_RETIRE_COUNT_EN
    chk("midrst_ret", retired, 0);
`endif
    @(negedge clk);
    reset_n = 1'b1;
    kick(16'hFFFF, 1'b0);
    chk("zero_illegal", illegal, 1);
    @(negedge clk);
    chk("zero_back", {w, illegal}, 2'b10);
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/srm_controller.md
Name: srm_controller

Overview:
- Instruction register (IR), decoder and multi-cycle control FSM for the Simple RISC Machine.
- Captures a 16-bit instruction, decodes it, and sequences the control inputs of the existing datapath: register reads, A/B/C/status loads, writeback.
- Sits between the instruction source (switches/memory) and the datapath. Drives every datapath control port.

Parameters:
- DATA_W, 16, datapath word width (sximm8 width).

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- s  in  1  start: begin executing IR contents
- load  in  1  capture `instr` into IR
- instr  in  16  instruction word
- w  out  1  1 = idle/waiting for s
- readnum  out  3  register-file read address
- writenum  out  3  register-file write address
- write  out  1  register-file write enable
- vsel  out  2  writeback select: 00 = C, 01 = PC, 10 = sximm8, 11 = mdata
- loada, loadb, loadc, loads  out  1 each  datapath register enables
- asel, bsel  out  1 each  A forced to 0 / B from sximm8
- shift  out  2  shifter op
- ALUop  out  2  ALU op
- sximm8  out  DATA_W  sign-extended IR[7:0]
- illegal  out  1  one-cycle pulse on unsupported encoding

Behaviour:
Instruction fields:
- opc = IR[15:13], op = IR[12:11], Rn = IR[10:8], Rd = IR[7:5], sh = IR[4:3], Rm = IR[2:0].
- Supported encodings:
  - 110/10 MOV Rn,#imm8
  - 110/00 MOV Rd,Rm{sh}
  - 101/00 ADD Rd,Rn,Rm{sh}
  - 101/01 CMP Rn,Rm{sh}
  - 101/10 AND Rd,Rn,Rm{sh}
  - 101/11 MVN Rd,Rm{sh}

Reset and IR loading:
- Reset (async, any state, mid-instruction included) forces state WAIT, IR = 0, and all outputs to idle values:
  - w = 1
  - write, loads, illegal = 0
  - vsel = 00, asel = bsel = 0, readnum = writenum = 000
  - shift and ALUop follow IR = 0
- IR loads only when load = 1 and state = WAIT. load is ignored in every other state.
- If load and s are asserted in the same WAIT cycle, the new word is captured and executed.

Output rules:
- All control outputs are Moore (decoded from state plus IR). Unlisted outputs are at idle values in each state.
- sximm8 = {{8{IR[7]}}, IR[7:0]}, always driven.
- shift = sh, always driven.
- ALUop = op, except MOV Rd,Rm, which drives 00 (ADD with A forced to 0).

States and transitions:
- WAIT: w = 1. s → DECODE; otherwise stay.
- DECODE: route by opcode.
  - MOV imm → WRITE_IMM
  - MOV reg, MVN → GET_B
  - ADD, CMP, AND → GET_A
  - anything else → WAIT, with illegal = 1 during this DECODE cycle
- GET_A: readnum = Rn, loada = 1 → GET_B.
- GET_B: readnum = Rm, loadb = 1 → ALU.
- ALU: bsel = 0, asel = 1 for MOV reg/MVN (else 0).
  - CMP: loads = 1 → WAIT.
  - otherwise: loadc = 1 → WRITE_REG.
- WRITE_REG: writenum = Rd, vsel = 00, write = 1 → WAIT.
- WRITE_IMM: writenum = Rn, vsel = 10, write = 1 → WAIT.

Latency (cycles with w = 0 after s is sampled):
- MOV imm: 2
- MOV reg, MVN, CMP: 4
- ADD, AND: 5

Boundary behaviour:
- s held high re-executes the current IR back-to-back. w = 1 for exactly one cycle between instructions.
- s is ignored outside WAIT.

Optional Feature:
- Macro SRM_RETIRE_COUNT_EN.
- Defined:
  - adds output port `retired` [15:0], reset to 0.
  - increments on entry to WAIT from WRITE_REG, WRITE_IMM, or ALU (CMP only).
  - wraps 0xFFFF → 0. Illegal encodings do not count.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Package srm_ctrl_pkg:
  - state enum (WAIT, DECODE, GET_A, GET_B, ALU, WRITE_REG, WRITE_IMM)
  - opcode/op localparams
  - vsel encodings VSEL_C / VSEL_PC / VSEL_IMM / VSEL_MDATA
- Sub-module srm_instr_decoder: combinational IR → fields, sximm8, instruction class, legal flag.

Test Plan:
- Reset mid-ADD (state GET_B) → immediately w = 1, loadb = 0, IR = 0. After release, s with IR = 0 → illegal pulse, return to WAIT.
- load + s with 0xD105 (MOV R1,#5) → DECODE, then WRITE_IMM with writenum = 1, vsel = 10, write = 1, sximm8 = 0x0005. w back to 1 after 2 cycles.
- MOV R2,#-1 (0xD2FF) → sximm8 = 0xFFFF in WRITE_IMM.
- ADD R2,R1,R0 LSL#1 (0xA148) → sequence GET_A (readnum = 1, loada) → GET_B (readnum = 0, loadb) → ALU (loadc, ALUop = 00, shift = 01) → WRITE_REG (writenum = 2, write). 5 cycles.
- CMP R1,R0 (0xA900) → ALU cycle has loads = 1, loadc = 0. No write. 4 cycles.
- load asserted during GET_A with a different word → IR unchanged, instruction completes correctly. With SRM_RETIRE_COUNT_EN, `retired` increments by exactly 1.
